// File: rtl/uart_rx_ovs_if.sv
// uart_rx_ovs_if: received-word handshake between the UART receiver and its consumer
interface uart_rx_ovs_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 break_det;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, break_det, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, break_det, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with programmable divisor, parity, 1/2 stop bits,
// error/break/overrun detection and a valid/ready word output
module uart_rx_ovs #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_in,
    input  logic [DIV_W-1:0] baud_div,
    uart_rx_ovs_if.master    bus
);
    localparam int H  = OVERSAMPLE / 2;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;

    state_t               state;
    logic                 rx_s1, rxs;
    logic [DIV_W-1:0]     div_q, div_cnt;
    logic [SW-1:0]        s_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] dsh;
    logic                 par_bit, fe_pend;
    logic                 tick, maj, dec, bit_end, fe_new, pe_new, brk_new;

    always_comb begin
        tick    = state != S_IDLE && div_cnt == div_q - DIV_W'(1);
        maj     = (smp[1] & smp[0]) | (smp[1] & rxs) | (smp[0] & rxs);
        dec     = tick && s_cnt == SW'(H + 1);
        bit_end = tick && s_cnt == SW'(OVERSAMPLE - 1);
        fe_new  = fe_pend | ~maj;
        pe_new  = (PARITY != 0) && (par_bit != ((PARITY == 2) ? ^dsh : ~^dsh));
        brk_new = dsh == '0 && (PARITY == 0 || !par_bit) && !maj;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            rx_s1           <= 1'b1;
            rxs             <= 1'b1;
            div_q           <= DIV_W'(1);
            div_cnt         <= '0;
            s_cnt           <= '0;
            bit_idx         <= '0;
            stop_idx        <= 1'b0;
            smp             <= '0;
            dsh             <= '0;
            par_bit         <= 1'b0;
            fe_pend         <= 1'b0;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.break_det   <= 1'b0;
            bus.overrun_err <= 1'b0;
        end else begin
            rx_s1           <= rx_in;
            rxs             <= rx_s1;
            bus.break_det   <= 1'b0;
            bus.overrun_err <= 1'b0;
            if (bus.rx_valid && bus.rx_ready)
                bus.rx_valid <= 1'b0;
            div_cnt <= (state == S_IDLE || tick) ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                s_cnt <= bit_end ? '0 : s_cnt + SW'(1);
                if (s_cnt == SW'(H - 1) || s_cnt == SW'(H))
                    smp <= {smp[0], rxs};
            end
            case (state)
                S_IDLE: begin
                    div_q <= (baud_div == '0) ? DIV_W'(1) : baud_div;
                    s_cnt <= '0;
                    if (!rxs) begin
                        state   <= S_START;
                        fe_pend <= 1'b0;
                    end
                end
                S_START: begin
                    if (dec && maj)
                        state <= S_IDLE;
                    else if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (dec)
                        dsh[bit_idx] <= maj;
                    if (bit_end) begin
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (dec)
                        par_bit <= maj;
                    if (bit_end)
                        state <= S_STOP;
                end
                S_STOP: begin
                    if (dec) begin
                        if (!maj)
                            fe_pend <= 1'b1;
                        // The final stop bit completes the frame at mid-bit so a following start edge is not missed
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            state         <= brk_new ? S_BRK_WAIT : S_IDLE;
                            bus.break_det <= brk_new;
                            if (!bus.rx_valid || bus.rx_ready) begin
                                bus.rx_data    <= dsh;
                                bus.frame_err  <= fe_new;
                                bus.parity_err <= pe_new;
                                bus.rx_valid   <= 1'b1;
                            end else
                                bus.overrun_err <= 1'b1;
                        end
                    end else if (bit_end)
                        stop_idx <= 1'b1;
                end
                S_BRK_WAIT: begin
                    if (rxs)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed checks of three receiver configurations (8N1, 8E1, 8N2) at baud_div=4
module tb_uart_rx_ovs;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  rx = 3'b111;
    logic [2:0]  rdy = 3'b000;
    logic [15:0] baud_div = 16'd4;
    int          checks = 0;
    int          failures = 0;
    int          brk_n = 0;
    int          ovr_n = 0;
    logic [9:0]  acc_q[$];

    uart_rx_ovs_if #(.DATA_BITS(8)) if0 ();
    uart_rx_ovs_if #(.DATA_BITS(8)) if1 ();
    uart_rx_ovs_if #(.DATA_BITS(8)) if2 ();

    assign if0.rx_ready = rdy[0];
    assign if1.rx_ready = rdy[1];
    assign if2.rx_ready = rdy[2];

    uart_rx_ovs #(.PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .reset_n(reset_n), .rx_in(rx[0]), .baud_div(baud_div), .bus(if0));
    uart_rx_ovs #(.PARITY(2), .STOP_BITS(1)) u1 (.clk(clk), .reset_n(reset_n), .rx_in(rx[1]), .baud_div(baud_div), .bus(if1));
    uart_rx_ovs #(.PARITY(0), .STOP_BITS(2)) u2 (.clk(clk), .reset_n(reset_n), .rx_in(rx[2]), .baud_div(baud_div), .bus(if2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if0.break_det) brk_n++;
        if (if0.overrun_err) ovr_n++;
        if (if0.rx_valid && if0.rx_ready) acc_q.push_back({if0.frame_err, if0.parity_err, if0.rx_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bit = 64 clk; optional 4-clk inverted pulse lands on exactly one of the three mid-bit samples
    task automatic send_bits(input int sel, input logic [31:0] bits, input int n, input int nb0 = -1, input int nb1 = -1);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < 64; c++) begin
                rx[sel] = ((i == nb0 || i == nb1) && c >= 34 && c < 38) ? ~bits[i] : bits[i];
                @(negedge clk);
            end
        rx[sel] = 1'b1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!if0.rx_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("valid_seen", if0.rx_valid, 1'b1);
    endtask

    task automatic accept(input int sel);
        rdy[sel] = 1'b1;
        @(negedge clk);
        rdy[sel] = 1'b0;
    endtask

    int cyc, q0, b0, o0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", {if2.rx_valid, if1.rx_valid, if0.rx_valid}, 3'b000);
        check("rst_data", if0.rx_data, 8'h00);
        check("rst_flags", {if0.frame_err, if0.parity_err, if0.break_det, if0.overrun_err}, 4'h0);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);

        fork
            send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
            wait_valid(cyc);
        join
        check("latency_ok", cyc >= 612 && cyc <= 626, 1'b1);
        check("a5_data", if0.rx_data, 8'hA5);
        check("a5_flags", {if0.frame_err, if0.parity_err}, 2'b00);
        repeat (200) @(negedge clk);
        check("a5_held", {if0.rx_valid, if0.rx_data}, {1'b1, 8'hA5});
        accept(0);
        check("a5_cleared", if0.rx_valid, 1'b0);

        send_bits(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
        check("par_ok", {if1.rx_valid, if1.rx_data, if1.parity_err}, {1'b1, 8'h03, 1'b0});
        accept(1);
        send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        check("par_bad", {if1.rx_valid, if1.rx_data, if1.parity_err}, {1'b1, 8'h03, 1'b1});
        accept(1);

        rx[0] = 1'b0;
        repeat (16) @(negedge clk);
        rx[0] = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_novalid", if0.rx_valid, 1'b0);
        send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
        check("after_glitch", {if0.rx_valid, if0.rx_data}, {1'b1, 8'h5A});
        accept(0);
        send_bits(0, {1'b1, 8'hF0, 1'b0}, 10, 2, 6);
        check("noise_maj", {if0.rx_valid, if0.rx_data, if0.frame_err}, {1'b1, 8'hF0, 1'b0});
        accept(0);

        q0 = acc_q.size();
        rdy[0] = 1'b1;
        send_bits(0, {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0}, 20);
        repeat (5) @(negedge clk);
        rdy[0] = 1'b0;
        check("b2b_count", acc_q.size() - q0, 2);
        if (acc_q.size() >= q0 + 2) begin
            check("b2b_first", acc_q[q0], {2'b00, 8'h55});
            check("b2b_second", acc_q[q0 + 1], {2'b00, 8'hAA});
        end
        o0 = ovr_n;
        send_bits(0, {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0}, 20);
        repeat (5) @(negedge clk);
        check("ovr_kept", {if0.rx_valid, if0.rx_data}, {1'b1, 8'h55});
        check("ovr_pulses", ovr_n - o0, 1);
        accept(0);

        b0 = brk_n;
        send_bits(2, {1'b0, 1'b1, 8'h81, 1'b0}, 11);
        repeat (100) @(negedge clk);
        check("stop2_err", {if2.rx_valid, if2.rx_data, if2.frame_err}, {1'b1, 8'h81, 1'b1});
        accept(2);

        q0 = acc_q.size();
        rdy[0] = 1'b1;
        rx[0] = 1'b0;
        repeat (12 * 64) @(negedge clk);
        check("brk_words", acc_q.size() - q0, 1);
        if (acc_q.size() > q0)
            check("brk_word", acc_q[q0], {2'b10, 8'h00});
        check("brk_pulse", brk_n - b0, 1);
        rx[0] = 1'b1;
        repeat (300) @(negedge clk);
        check("brk_nomore", acc_q.size() - q0, 1);
        rdy[0] = 1'b0;

        send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
        check("pre_rst", if0.rx_valid, 1'b1);
        send_bits(0, {1'b1, 8'h22, 1'b0}, 5);
        reset_n = 1'b0;
        #1;
        check("rst_async", {if0.rx_valid, if0.rx_data, if0.frame_err}, 10'h000);
        @(negedge clk);
        rx[0] = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        check("rst_nopartial", if0.rx_valid, 1'b0);
        send_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
        check("post_rst", {if0.rx_valid, if0.rx_data, if0.frame_err, if0.parity_err}, {1'b1, 8'h3C, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
